// File: rtl/mem_access_lsu.sv
// rtl/mem_access_lsu.sv - load/store unit for the memory-access phase, splits boundary-crossing accesses into two beats
module mem_access_lsu #(
    parameter int XLEN        = 64,
    parameter int AWIDTH      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [AWIDTH-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [XLEN-1:0]     load_data,
    output logic                done,
    output logic                access_err,
    output logic                stall_memoryaccess
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic              load_q;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;
    logic [XLEN-1:0]   rd0_q;

    // Request decode on the raw inputs, needed in the start cycle itself
    logic [3:0] req_bytes;
    logic       req_misal;
    logic       req_split;
    logic       req_illegal;
    logic       req_valid;

    always_comb begin
        req_bytes = 4'd8;
        case (funct3[1:0])
            2'd0:    req_bytes = 4'd1;
            2'd1:    req_bytes = 4'd2;
            2'd2:    req_bytes = 4'd4;
            default: req_bytes = 4'd8;
        endcase
    end

    assign req_misal = (addr[2:0] & (req_bytes[2:0] - 3'd1)) != 3'd0;
    assign req_split = (5'(addr[OFFW-1:0]) + 5'(req_bytes)) > 5'(NB);
    assign req_valid = is_load | is_store;

    always_comb begin
        req_illegal = 1'b0;
        if (funct3 == 3'b111)
            req_illegal = 1'b1;
        if ((XLEN == 32) && ((funct3[1:0] == 2'd3) || (funct3 == 3'b110)))
            req_illegal = 1'b1;
        if ((MISALIGN_EN == 0) && (req_misal || req_split))
            req_illegal = 1'b1;
    end

    // Decode of the latched request, used while the beats are in flight
    logic [1:0]      size_q;
    logic [OFFW-1:0] off_q;
    logic [3:0]      bytes_q;
    logic            split_q;
    logic [OFFW+2:0] shamt;

    assign size_q = f3_q[1:0];
    assign off_q  = addr_q[OFFW-1:0];
    assign shamt  = {off_q, 3'b000};

    always_comb begin
        bytes_q = 4'd8;
        case (size_q)
            2'd0:    bytes_q = 4'd1;
            2'd1:    bytes_q = 4'd2;
            2'd2:    bytes_q = 4'd4;
            default: bytes_q = 4'd8;
        endcase
    end

    assign split_q = (5'(off_q) + 5'(bytes_q)) > 5'(NB);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (req_valid && !req_illegal) ? S_BEAT0 : S_DONE;
            end
            S_BEAT0: begin
                if (mem_ack)
                    state_d = split_q ? S_BEAT1 : S_DONE;
            end
            S_BEAT1: begin
                if (mem_ack)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    logic in_beat1;
    assign in_beat1 = (state_q == S_BEAT1);

    // Store lanes: a double-width window so the spill-over lands in beat 1
    logic [2*NB-1:0]   mask_base;
    logic [2*NB-1:0]   be_full;
    logic [XLEN-1:0]   wd_sized;
    logic [2*XLEN-1:0] wd_full;

    always_comb begin
        mask_base = (2*NB)'(8'hFF);
        wd_sized  = wdata_q;
        case (size_q)
            2'd0: begin
                mask_base = (2*NB)'(8'h01);
                wd_sized  = XLEN'(wdata_q[7:0]);
            end
            2'd1: begin
                mask_base = (2*NB)'(8'h03);
                wd_sized  = XLEN'(wdata_q[15:0]);
            end
            2'd2: begin
                mask_base = (2*NB)'(8'h0F);
                wd_sized  = XLEN'(wdata_q[31:0]);
            end
            default: begin
                mask_base = (2*NB)'(8'hFF);
                wd_sized  = wdata_q;
            end
        endcase
    end

    assign be_full = mask_base << off_q;
    assign wd_full = {{XLEN{1'b0}}, wd_sized} << shamt;

    logic [AWIDTH-1:0] base_addr;
    assign base_addr = {addr_q[AWIDTH-1:OFFW], {OFFW{1'b0}}};

    assign mem_req            = (state_q == S_BEAT0) || in_beat1;
    assign mem_we             = mem_req & store_q;
    assign mem_addr           = in_beat1 ? (base_addr + AWIDTH'(NB)) : base_addr;
    assign mem_wdata          = in_beat1 ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0];
    assign mem_be             = mem_req ? (in_beat1 ? be_full[2*NB-1:NB] : be_full[NB-1:0])
                                        : '0;
    assign stall_memoryaccess = mem_req;
    assign done               = (state_q == S_DONE);
    assign access_err         = done & err_q;

    // Load assembly uses the live bus data for the final beat
    logic [XLEN-1:0] rd_lo;
    logic [XLEN-1:0] rd_hi;
    logic [XLEN-1:0] rd_raw;
    logic [63:0]     raw64;
    logic [63:0]     ext64;
    logic            sgn;
    logic            load_fin;

    assign rd_lo  = in_beat1 ? rd0_q : mem_rdata;
    assign rd_hi  = in_beat1 ? mem_rdata : '0;
    assign rd_raw = XLEN'({rd_hi, rd_lo} >> shamt);
    assign raw64  = 64'(rd_raw);
    assign sgn    = ~f3_q[2];

    always_comb begin
        ext64 = raw64;
        case (size_q)
            2'd0:    ext64 = {{56{sgn & raw64[7]}},  raw64[7:0]};
            2'd1:    ext64 = {{48{sgn & raw64[15]}}, raw64[15:0]};
            2'd2:    ext64 = {{32{sgn & raw64[31]}}, raw64[31:0]};
            default: ext64 = raw64;
        endcase
    end

    assign load_fin = mem_ack && load_q &&
                      (((state_q == S_BEAT0) && !split_q) || in_beat1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd0_q     <= '0;
            load_data <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                load_q  <= is_load;
                store_q <= is_store & ~is_load;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= req_valid & req_illegal;
            end
            if ((state_q == S_BEAT0) && mem_ack)
                rd0_q <= mem_rdata;
            if (load_fin)
                load_data <= ext64[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_mem_access_lsu.sv
// tb/tb_mem_access_lsu.sv - directed self-checking bench for mem_access_lsu
module tb_mem_access_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, start32, startna;
    logic        is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        mem_ack, ack_aux;
    logic [63:0] mem_rdata, rdata_na;
    logic [31:0] rdata32;

    logic        mem_req, mem_we, done, access_err, stall;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, load_data;
    logic [7:0]  mem_be;

    logic        req32, we32, done32, err32, stall32;
    logic [31:0] addr32, wdata32, ld32;
    logic [3:0]  be32;

    logic        reqna, wena, donena, errna, stallna;
    logic [31:0] addrna;
    logic [63:0] wdatana, ldna;
    logic [7:0]  bena;

    mem_access_lsu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .load_data(load_data), .done(done), .access_err(access_err),
        .stall_memoryaccess(stall)
    );

    mem_access_lsu #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata[31:0]), .mem_req(req32), .mem_we(we32),
        .mem_addr(addr32), .mem_wdata(wdata32), .mem_be(be32), .mem_ack(ack_aux),
        .mem_rdata(rdata32), .load_data(ld32), .done(done32), .access_err(err32),
        .stall_memoryaccess(stall32)
    );

    mem_access_lsu #(.MISALIGN_EN(0)) dutna (
        .clk(clk), .rst_n(rst_n), .start(startna), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .mem_req(reqna), .mem_we(wena),
        .mem_addr(addrna), .mem_wdata(wdatana), .mem_be(bena), .mem_ack(ack_aux),
        .mem_rdata(rdata_na), .load_data(ldna), .done(donena), .access_err(errna),
        .stall_memoryaccess(stallna)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [63:0] wd);
        is_load  = ld;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic beat(input int wt, input logic [63:0] rd);
        repeat (wt) tick();
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; start32 = 1'b0; startna = 1'b0;
        is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
        mem_ack = 1'b0; ack_aux = 1'b1; mem_rdata = '0; rdata_na = '0; rdata32 = '0;
        repeat (2) tick();
        chk("reset_req", mem_req, 1'b0);
        chk("reset_we", mem_we, 1'b0);
        chk("reset_be", mem_be, 8'h00);
        chk("reset_done", done, 1'b0);
        chk("reset_err", access_err, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_ld", load_data, 64'h0);
        rst_n = 1'b1;
        tick();

        mem_ack = 1'b1;
        tick();
        chk("idle_ack_done", done, 1'b0);
        chk("idle_ack_req", mem_req, 1'b0);
        mem_ack = 1'b0;

        // sb at offset 3
        issue(1'b0, 1'b1, 3'b000, 32'h3, 64'h55);
        chk("sb_req", mem_req, 1'b1);
        chk("sb_we", mem_we, 1'b1);
        chk("sb_addr", mem_addr, 32'h0);
        chk("sb_be", mem_be, 8'h08);
        chk("sb_wdata", mem_wdata[31:24], 8'h55);
        chk("sb_stall", stall, 1'b1);
        beat(0, 64'h0);
        chk("sb_done", done, 1'b1);
        chk("sb_err", access_err, 1'b0);
        chk("sb_req_off", mem_req, 1'b0);
        chk("sb_stall_off", stall, 1'b0);
        tick();
        chk("sb_done_pulse", done, 1'b0);
        chk("sb_ld_keep", load_data, 64'h0);

        // ld with ack three cycles late
        issue(1'b1, 1'b0, 3'b011, 32'h10, 64'h0);
        chk("ld_addr", mem_addr, 32'h10);
        chk("ld_be", mem_be, 8'hFF);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (stall === 1'b1) n++;
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 64'h0000_5555_AAAA_FFFF;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("ld_stall_cycles", 64'(n), 64'd4);
        chk("ld_done", done, 1'b1);
        tick();
        chk("ld_data", load_data, 64'h0000_5555_AAAA_FFFF);

        // lw crossing the 8-byte boundary
        issue(1'b1, 1'b0, 3'b010, 32'h6, 64'h0);
        chk("lw_b0_addr", mem_addr, 32'h0);
        chk("lw_b0_be", mem_be, 8'hC0);
        beat(1, 64'hEFEF_0000_0000_0000);
        chk("lw_b1_addr", mem_addr, 32'h8);
        chk("lw_b1_be", mem_be, 8'h03);
        chk("lw_b1_stall", stall, 1'b1);
        beat(0, 64'h0000_0000_0000_EFEF);
        chk("lw_done", done, 1'b1);
        tick();
        chk("lw_data", load_data, 64'hFFFF_FFFF_EFEF_EFEF);

        issue(1'b1, 1'b0, 3'b110, 32'h6, 64'h0);
        beat(0, 64'hEFEF_0000_0000_0000);
        beat(0, 64'h0000_0000_0000_EFEF);
        chk("lwu_done", done, 1'b1);
        tick();
        chk("lwu_data", load_data, 64'h0000_0000_EFEF_EFEF);

        // byte and half loads at offset 4
        issue(1'b1, 1'b0, 3'b000, 32'hC, 64'h0);
        chk("lb_addr", mem_addr, 32'h8);
        chk("lb_be", mem_be, 8'h10);
        beat(0, 64'h0000_00FF_0000_0000);
        tick();
        chk("lb_data", load_data, 64'hFFFF_FFFF_FFFF_FFFF);

        issue(1'b1, 1'b0, 3'b100, 32'hC, 64'h0);
        beat(0, 64'h0000_00FF_0000_0000);
        tick();
        chk("lbu_data", load_data, 64'h0000_0000_0000_00FF);

        issue(1'b1, 1'b0, 3'b001, 32'hC, 64'h0);
        chk("lh_be", mem_be, 8'h30);
        beat(0, 64'h0000_AAAA_0000_0000);
        tick();
        chk("lh_data", load_data, 64'hFFFF_FFFF_FFFF_AAAA);

        // split sw; a start during the beat must be ignored
        issue(1'b0, 1'b1, 3'b010, 32'h6, 64'h0000_0000_AABB_CCDD);
        chk("sw6_b0_be", mem_be, 8'hC0);
        chk("sw6_b0_wdata", mem_wdata, 64'hCCDD_0000_0000_0000);
        addr  = 32'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sw6_hold_addr", mem_addr, 32'h0);
        chk("sw6_hold_be", mem_be, 8'hC0);
        beat(0, 64'h0);
        chk("sw6_b1_addr", mem_addr, 32'h8);
        chk("sw6_b1_be", mem_be, 8'h03);
        chk("sw6_b1_wdata", mem_wdata, 64'h0000_0000_0000_AABB);
        beat(0, 64'h0);
        chk("sw6_done", done, 1'b1);
        tick();
        chk("sw6_ld_keep", load_data, 64'hFFFF_FFFF_FFFF_AAAA);

        // neither load nor store
        issue(1'b0, 1'b0, 3'b010, 32'h0, 64'h0);
        chk("nop_req", mem_req, 1'b0);
        chk("nop_done", done, 1'b1);
        chk("nop_err", access_err, 1'b0);
        tick();

        // ld on a 32-bit unit is illegal
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 32'h0;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        chk("x32_req", req32, 1'b0);
        chk("x32_done", done32, 1'b1);
        chk("x32_err", err32, 1'b1);
        tick();
        chk("x32_done_off", done32, 1'b0);

        // misaligned sh with splitting disabled, then an aligned one
        is_load = 1'b0; is_store = 1'b1; funct3 = 3'b001; addr = 32'h3;
        startna = 1'b1;
        tick();
        startna = 1'b0;
        chk("na_req", reqna, 1'b0);
        chk("na_done", donena, 1'b1);
        chk("na_err", errna, 1'b1);
        tick();
        addr = 32'h2;
        startna = 1'b1;
        tick();
        startna = 1'b0;
        chk("na_ok_req", reqna, 1'b1);
        chk("na_ok_be", bena, 8'h0C);
        tick();
        chk("na_ok_done", donena, 1'b1);
        chk("na_ok_err", errna, 1'b0);
        tick();

        // reset while waiting in beat 0
        issue(1'b1, 1'b0, 3'b011, 32'h20, 64'h0);
        chk("rst_pre_req", mem_req, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ld", load_data, 64'h0);
        tick();
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_idle_done", done, 1'b0);

        issue(1'b0, 1'b1, 3'b010, 32'h8, 64'h0000_0000_1234_5678);
        chk("post_rst_addr", mem_addr, 32'h8);
        chk("post_rst_be", mem_be, 8'h0F);
        chk("post_rst_wdata", mem_wdata[31:0], 32'h1234_5678);
        beat(0, 64'h0);
        chk("post_rst_done", done, 1'b1);
        chk("post_rst_err", access_err, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_lsu.md
MEM_ACCESS_LSU -- requirements
Module: mem_access_lsu

Interface
REQ-001 Parameter XLEN, default 64, data width; legal values 32 or 64.
REQ-002 Parameter AWIDTH, default 32, byte-address width.
REQ-003 Parameter MISALIGN_EN, default 1; 1 = split boundary-crossing accesses, 0 = flag them as errors.
REQ-004 Port clk  input  1  global clock, rising edge.
REQ-005 Port rst_n  input  1  global reset, asynchronous, active-low.
REQ-006 Port start  input  1  one-cycle request pulse, memory-access phase entry.
REQ-007 Port is_load / is_store  input  1 each  access type, sampled at start.
REQ-008 Port funct3  input  3  size [1:0] (0 B, 1 H, 2 W, 3 D) plus [2] unsigned load.
REQ-009 Port addr  input  AWIDTH  byte address; wdata  input  XLEN  store data, LSB-aligned.
REQ-010 Port mem_req  output  1  bus request; mem_we  output  1  write beat.
REQ-011 Port mem_addr  output  AWIDTH  beat address, aligned to XLEN/8.
REQ-012 Port mem_wdata  output  XLEN; mem_be  output  XLEN/8  byte enables.
REQ-013 Port mem_ack  input  1  beat complete; mem_rdata  input  XLEN  read data, valid with ack.
REQ-014 Port load_data  output  XLEN  extended load result.
REQ-015 Port done  output  1  one-cycle completion pulse; access_err  output  1  error, valid with done.
REQ-016 Port stall_memoryaccess  output  1  stall request to state machine.

Function
REQ-017 Request fields are latched at start in IDLE; start outside IDLE is ignored.
REQ-018 FSM states are IDLE, BEAT0, BEAT1 and DONE.
REQ-019 IDLE on a legal start goes to BEAT0; on an illegal start or neither-load-nor-store it goes to DONE with no bus activity.
REQ-020 Illegal access is size D or funct3=WU when XLEN=32, funct3=DU, or any misaligned access when MISALIGN_EN=0; it sets access_err=1 in DONE.
REQ-021 An access is split when (addr mod XLEN/8) + size_bytes > XLEN/8.
REQ-022 BEAT0 drives mem_req=1 at floor(addr); on ack it goes to BEAT1 if split, else to DONE.
REQ-023 BEAT1 drives mem_req=1 at floor(addr)+XLEN/8; on ack it goes to DONE.
REQ-024 mem_addr, mem_wdata, mem_be and mem_we are held stable while mem_req=1 and ack is low.
REQ-025 Ack in the same cycle as req (zero-wait) is legal; ack seen in IDLE or DONE is ignored.
REQ-026 Store lanes: wdata is shifted left by offset*8 with be = size mask << offset; split bits go to beat1 with the matching be.
REQ-027 Load: beat rdata is captured on ack, bytes are concatenated from offset, then zero- or sign-extended to XLEN per funct3[2].
REQ-028 load_data updates on the cycle after the DONE transition and holds until the next completed load; stores do not change it.
REQ-029 stall_memoryaccess is 1 in BEAT0 and BEAT1, 0 in IDLE and DONE.
REQ-030 done is 1 only in DONE, one cycle; DONE always returns to IDLE.

Reset
REQ-031 rst_n low asynchronously forces IDLE and drives mem_req, mem_we, mem_be, done, access_err, stall_memoryaccess and load_data to 0.
REQ-032 Reset mid-transaction aborts the access with no done pulse; the first start after release is served normally.

Verification
REQ-033 XLEN=64, sb addr 0x3, wdata 0x55 -> one beat, mem_addr 0x0, mem_be 0x08, mem_wdata[31:24]=0x55, done after ack.
REQ-034 ld addr 0x10, ack 3 cycles late, rdata 0x0000_5555_AAAA_FFFF -> stall high 4 cycles, load_data 0x0000_5555_AAAA_FFFF.
REQ-035 lw addr 0x6, beat0 0x0 be 0xC0 rdata 0xEFEF_0000_0000_0000, beat1 0x8 be 0x03 rdata 0xEFEF -> load_data 0xFFFF_FFFF_EFEF_EFEF; lwu gives 0x0000_0000_EFEF_EFEF.
REQ-036 lb addr 0xC, byte 0xFF -> 0xFFFF_FFFF_FFFF_FFFF; lbu gives 0x0000_0000_0000_00FF; lh 0xAAAA gives 0xFFFF_FFFF_FFFF_AAAA.
REQ-037 XLEN=32 ld, or MISALIGN_EN=0 sh addr 0x3 -> no mem_req, done and access_err high on the cycle after start.
REQ-038 rst_n low during BEAT0 wait -> mem_req 0 immediately, no done; after release sw addr 0x8 completes in one beat, be 0x0F.
